// File: rtl/pipeline_slice.sv
// Ready/valid register slice: a main entry plus one skid entry, fully
// registered outputs, and a synchronous flush that squashes both entries.
module pipeline_slice #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] INITIAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_next;
  logic [WIDTH-1:0] w_skid_next;
  logic             w_main_we;
  logic             w_skid_we;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = (r_state != S_EMPTY) && out_ready;

  always_comb begin
    w_next      = r_state;
    w_main_we   = 1'b0;
    w_skid_we   = 1'b0;
    w_main_next = in_data;
    w_skid_next = in_data;
    if (flush) begin
      // Flush wins: the handshakes still complete, but no data is kept.
      w_next      = S_EMPTY;
      w_main_we   = 1'b1;
      w_skid_we   = 1'b1;
      w_main_next = INITIAL;
      w_skid_next = INITIAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_main_we = 1'b1;
            w_next    = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_we = 1'b1;
          end else if (w_in_xfer) begin
            w_skid_we = 1'b1;
            w_next    = S_FULL;
          end else if (w_out_xfer) begin
            w_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            w_main_we   = 1'b1;
            w_main_next = r_skid;
            w_next      = S_ONE;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_main     <= INITIAL;
      r_skid     <= INITIAL;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
      if (w_main_we) r_main <= w_main_next;
      if (w_skid_we) r_skid <= w_skid_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;
  assign count     = {r_state == S_FULL, r_state == S_ONE};

endmodule
